// File: rtl/transmit_sequencer_if.sv
// Bus bundle between the transmit sequencer, its message RAM, the UART transmitter
// and the controlling logic. The sequencer uses the master side.
interface transmit_sequencer_if #(
  parameter int DataLength  = 7,
  parameter int AddressBits = 5
);
  logic                   Start;
  logic                   ReadOrWrite;
  logic [AddressBits-1:0] Address;
  logic [DataLength-1:0]  RAMData;
  logic [DataLength-1:0]  TxData;
  logic                   TxValid;
  logic                   TxReady;
  logic                   Busy;
  logic                   Done;
  logic [AddressBits:0]   SentCount;

  modport master (
    input  Start, RAMData, TxReady,
    output ReadOrWrite, Address, TxData, TxValid, Busy, Done, SentCount
  );

  modport slave (
    output Start, RAMData, TxReady,
    input  ReadOrWrite, Address, TxData, TxValid, Busy, Done, SentCount
  );
endinterface

// File: rtl/transmit_sequencer.sv
// Streams a MessageLength-character message from a registered-read RAM to a UART
// transmitter. Optional build macro NULL_STOP_EN ends the message at a zero character.
module transmit_sequencer #(
  parameter int DataLength    = 7,
  parameter int AddressBits   = 5,
  parameter int MessageLength = 21
) (
  input  logic                 Clock,
  input  logic                 Reset,
  transmit_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    READ = 3'd1,
    WAIT = 3'd2,
    SEND = 3'd3,
    DONE = 3'd4
  } state_t;

  localparam logic [AddressBits-1:0] LastIndex = AddressBits'(MessageLength - 1);
  localparam logic [AddressBits-1:0] IndexOne  = AddressBits'(1'b1);
  localparam logic [AddressBits:0]   CountOne  = (AddressBits + 1)'(1'b1);

  state_t                 state_r;
  state_t                 next_state_s;
  logic [AddressBits-1:0] index_r;
  logic [DataLength-1:0]  tx_data_r;
  logic [AddressBits:0]   sent_count_r;
  logic                   tx_valid_r;
  logic                   busy_r;
  logic                   done_r;
  logic                   tx_valid_s;
  logic                   busy_s;
  logic                   done_s;
  logic                   handshake_s;
  logic                   null_char_s;

  assign handshake_s = (state_r == SEND) && bus.TxReady;

`ifdef NULL_STOP_EN
  assign null_char_s = (bus.RAMData == {DataLength{1'b0}});
`else
  assign null_char_s = 1'b0;
`endif

  // State register.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic; Start only matters in IDLE, TxReady only in SEND.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.Start) begin
          next_state_s = READ;
        end else begin
          next_state_s = IDLE;
        end
      end
      READ: begin
        next_state_s = WAIT;
      end
      WAIT: begin
        if (null_char_s) begin
          next_state_s = DONE;
        end else begin
          next_state_s = SEND;
        end
      end
      SEND: begin
        if (!handshake_s) begin
          next_state_s = SEND;
        end else if (index_r == LastIndex) begin
          next_state_s = DONE;
        end else begin
          next_state_s = READ;
        end
      end
      DONE: begin
        next_state_s = IDLE;
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // Output decode from the upcoming state so the status outputs leave a flop.
  always_comb begin
    tx_valid_s = 1'b0;
    busy_s     = 1'b0;
    done_s     = 1'b0;
    case (next_state_s)
      IDLE: begin
        busy_s = 1'b0;
      end
      SEND: begin
        tx_valid_s = 1'b1;
        busy_s     = 1'b1;
      end
      DONE: begin
        done_s = 1'b1;
        busy_s = 1'b1;
      end
      default: begin
        busy_s = 1'b1;
      end
    endcase
  end

  // Status output registers.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      tx_valid_r <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      tx_valid_r <= tx_valid_s;
      busy_r     <= busy_s;
      done_r     <= done_s;
    end
  end

  // Character index, captured character and handshake counter.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      index_r      <= {AddressBits{1'b0}};
      tx_data_r    <= {DataLength{1'b0}};
      sent_count_r <= {(AddressBits + 1){1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          index_r <= {AddressBits{1'b0}};
          if (bus.Start) begin
            sent_count_r <= {(AddressBits + 1){1'b0}};
          end
        end
        WAIT: begin
          tx_data_r <= bus.RAMData;
        end
        SEND: begin
          if (handshake_s) begin
            sent_count_r <= sent_count_r + CountOne;
            // The last index stays put; DONE clears it.
            if (index_r != LastIndex) begin
              index_r <= index_r + IndexOne;
            end
          end
        end
        DONE: begin
          index_r <= {AddressBits{1'b0}};
        end
        default: begin
          index_r <= index_r;
        end
      endcase
    end
  end

  assign bus.ReadOrWrite = 1'b1;
  assign bus.Address     = index_r;
  assign bus.TxData      = tx_data_r;
  assign bus.TxValid     = tx_valid_r;
  assign bus.Busy        = busy_r;
  assign bus.Done        = done_r;
  assign bus.SentCount   = sent_count_r;

endmodule

// File: tb/tb_transmit_sequencer.sv
// Self-checking bench for transmit_sequencer: a per-cycle expectation is built from the
// message contents and the TxReady pattern, then compared against the running DUT.
module tb_transmit_sequencer;

  localparam int ML        = 21;
  localparam int MaxCycles = 400;

  logic Clock = 1'b0;
  logic Reset;

  transmit_sequencer_if #(.DataLength(7), .AddressBits(5)) bus_if ();

  transmit_sequencer #(.DataLength(7), .AddressBits(5), .MessageLength(ML)) dut (
    .Clock(Clock),
    .Reset(Reset),
    .bus  (bus_if.master)
  );

  always #5 Clock = ~Clock;

  logic [6:0] mem [0:31];

  // Registered-read message RAM.
  always_ff @(posedge Clock) begin
    bus_if.RAMData <= mem[bus_if.Address];
  end

  int checks = 0;
  int errors = 0;
  int obs_done;
  int n_chars;
  int e_end;
  bit ready_a [0:MaxCycles-1];
  bit e_valid [0:MaxCycles-1];
  bit e_done  [0:MaxCycles-1];
  bit e_busy  [0:MaxCycles-1];
  int e_data  [0:MaxCycles-1];
  int e_addr  [0:MaxCycles-1];
  int e_sent  [0:MaxCycles-1];
  int hs      [0:31];

  task automatic check_eq(input string tag, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, actual, expected);
    end
  endtask

  task automatic check_idle_state(input string tag);
    check_eq({tag, "_rw"},    int'(bus_if.ReadOrWrite), 1);
    check_eq({tag, "_valid"}, int'(bus_if.TxValid), 0);
    check_eq({tag, "_busy"},  int'(bus_if.Busy), 0);
    check_eq({tag, "_done"},  int'(bus_if.Done), 0);
    check_eq({tag, "_sent"},  int'(bus_if.SentCount), 0);
    check_eq({tag, "_addr"},  int'(bus_if.Address), 0);
    check_eq({tag, "_data"},  int'(bus_if.TxData), 0);
  endtask

  // Reference: READ and WAIT take one cycle each, SEND lasts until TxReady is seen.
  function automatic void build_model();
    int cur;
    int c;
    for (int t = 0; t < MaxCycles; t++) begin
      e_valid[t] = 1'b0;
      e_done[t]  = 1'b0;
      e_busy[t]  = 1'b0;
      e_data[t]  = 0;
      e_addr[t]  = -1;
      e_sent[t]  = 0;
    end
    n_chars = ML;
`ifdef NULL_STOP_EN
    for (int k = ML - 1; k >= 0; k--) begin
      if (mem[k] == 7'd0) n_chars = k;
    end
`endif
    cur = 0;
    for (int k = 0; k < n_chars; k++) begin
      e_addr[cur + 1] = k;
      c = cur + 3;
      while (c < MaxCycles - 1 && !ready_a[c]) c++;
      for (int t = cur + 3; t <= c; t++) begin
        e_valid[t] = 1'b1;
        e_data[t]  = int'(mem[k]);
      end
      hs[k] = c;
      cur = c;
    end
    if (n_chars < ML) begin
      e_addr[cur + 1] = n_chars;
      e_end = cur + 3;
    end else begin
      e_end = cur + 1;
    end
    for (int t = 1; t <= e_end; t++) e_busy[t] = 1'b1;
    e_done[e_end] = 1'b1;
    for (int t = e_end + 1; t < MaxCycles; t++) e_addr[t] = 0;
    for (int t = 1; t < MaxCycles; t++) begin
      for (int k = 0; k < n_chars; k++) begin
        if (hs[k] < t) e_sent[t]++;
      end
    end
  endfunction

  task automatic check_cycle(input int c);
    check_eq($sformatf("rw@%0d", c),    int'(bus_if.ReadOrWrite), 1);
    check_eq($sformatf("valid@%0d", c), int'(bus_if.TxValid), int'(e_valid[c]));
    check_eq($sformatf("busy@%0d", c),  int'(bus_if.Busy), int'(e_busy[c]));
    check_eq($sformatf("done@%0d", c),  int'(bus_if.Done), int'(e_done[c]));
    check_eq($sformatf("sent@%0d", c),  int'(bus_if.SentCount), e_sent[c]);
    if (e_valid[c]) check_eq($sformatf("data@%0d", c), int'(bus_if.TxData), e_data[c]);
    if (e_addr[c] >= 0) check_eq($sformatf("addr@%0d", c), int'(bus_if.Address), e_addr[c]);
  endtask

  // Start in cycle 0, then one check per cycle; optional extra Start pulses and a reset.
  task automatic run_message(input int reset_cycle, input int pulse_cycle, input bit noise);
    int last;
    build_model();
    obs_done = -1;
    last = (reset_cycle >= 0) ? reset_cycle : e_end + 2;
    @(posedge Clock); #1;
    bus_if.Start   = 1'b1;
    bus_if.TxReady = ready_a[0];
    @(posedge Clock); #1;
    for (int c = 1; c <= last; c++) begin
      if (c > 1) begin
        @(posedge Clock); #1;
      end
      bus_if.TxReady = ready_a[c];
      bus_if.Start   = (c == pulse_cycle) || (noise && c < e_end && $urandom_range(0, 3) == 0);
      if (c == reset_cycle) Reset = 1'b1;
      @(negedge Clock);
      check_cycle(c);
      if (bus_if.Done && obs_done < 0) obs_done = c;
    end
    if (reset_cycle >= 0) begin
      @(posedge Clock); #1;
      Reset = 1'b0;
      bus_if.Start = 1'b0;
      @(negedge Clock);
      check_idle_state("after_reset");
    end
    bus_if.Start   = 1'b0;
    bus_if.TxReady = 1'b0;
  endtask

  task automatic load_ece_message();
    string s;
    byte   b;
    s = "ECE433 Fall  2020";
    for (int i = 0; i < 32; i++) mem[i] = 7'd0;
    for (int i = 0; i < 17; i++) begin
      b = s[i];
      mem[i] = b[6:0];
    end
    mem[17] = 7'h0A;
    mem[18] = 7'h0D;
    mem[19] = 7'h0A;
    mem[20] = 7'h00;
  endtask

  task automatic set_ready_all(input bit v);
    for (int t = 0; t < MaxCycles; t++) ready_a[t] = v;
  endtask

  initial begin
    int exp_done_cycle;
    int exp_count;
`ifdef NULL_STOP_EN
    exp_done_cycle = 63;
    exp_count      = 20;
`else
    exp_done_cycle = 64;
    exp_count      = 21;
`endif
    load_ece_message();
    Reset          = 1'b1;
    bus_if.Start   = 1'b1;
    bus_if.TxReady = 1'b1;
    repeat (3) @(posedge Clock);
    @(negedge Clock);
    check_idle_state("reset");
    @(posedge Clock); #1;
    Reset        = 1'b0;
    bus_if.Start = 1'b0;
    @(negedge Clock);
    check_idle_state("post_reset");

    // Full message with TxReady held high.
    set_ready_all(1'b1);
    run_message(-1, -1, 1'b0);
    check_eq("full_done_cycle", obs_done, exp_done_cycle);
    check_eq("full_sent_final", int'(bus_if.SentCount), exp_count);

    // Start re-pulsed mid-message.
    run_message(-1, 10, 1'b0);
    check_eq("repulse_done_cycle", obs_done, exp_done_cycle);
    check_eq("repulse_sent_final", int'(bus_if.SentCount), exp_count);

    // TxReady low for the first five SEND cycles.
    set_ready_all(1'b1);
    for (int t = 3; t <= 7; t++) ready_a[t] = 1'b0;
    run_message(-1, -1, 1'b0);
    check_eq("stall_sent_final", int'(bus_if.SentCount), exp_count);

    // Reset in the SEND cycle of index 7, then a clean restart.
    set_ready_all(1'b1);
    run_message(24, -1, 1'b0);
    run_message(-1, -1, 1'b0);
    check_eq("restart_done_cycle", obs_done, exp_done_cycle);

    // Random messages, random TxReady and stray Start pulses.
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < 32; i++) begin
        mem[i] = ($urandom_range(0, 7) == 0) ? 7'd0 : 7'($urandom_range(1, 127));
      end
      for (int t = 0; t < MaxCycles; t++) begin
        ready_a[t] = (t >= 200) ? 1'b1 : ($urandom_range(0, 2) != 0);
      end
      run_message(-1, -1, 1'b1);
      check_eq($sformatf("rand%0d_done_cycle", r), obs_done, e_end);
      check_eq($sformatf("rand%0d_sent_final", r), int'(bus_if.SentCount), n_chars);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/transmit_sequencer.md
TRANSMIT_SEQUENCER -- requirements
Module: transmit_sequencer

Interface
REQ-001 Parameter DataLength, default 7: width of the message character and TxData.
REQ-002 Parameter AddressBits, default 5: width of the message RAM address.
REQ-003 Parameter MessageLength, default 21: number of characters in one message; SHALL be >=1 and <=2**AddressBits.
REQ-004 Clock  input  1  single clock; all state changes on its rising edge.
REQ-005 Reset  input  1  synchronous, active-high reset, sampled on the rising edge of Clock.
REQ-006 Start  input  1  request to transmit one message; sampled only in IDLE.
REQ-007 ReadOrWrite  output  1  message RAM mode; 1 = read.
REQ-008 Address  output  AddressBits  message RAM address; equals the internal index.
REQ-009 RAMData  input  DataLength  message RAM registered read data, valid one cycle after the address is presented.
REQ-010 TxData  output  DataLength  character offered to the UART transmitter.
REQ-011 TxValid  output  1  TxData valid; transfer occurs on an edge where TxValid and TxReady are both 1.
REQ-012 TxReady  input  1  UART transmitter can accept a character.
REQ-013 Busy  output  1  high in every state except IDLE.
REQ-014 Done  output  1  one-cycle pulse at message end.
REQ-015 SentCount  output  AddressBits+1  characters handshaken since the last accepted Start.

Function
REQ-016 ReadOrWrite SHALL be driven constant 1 in all states, including during reset; the sequencer never writes the RAM.
REQ-017 States: IDLE, READ, WAIT, SEND, DONE; all outputs registered or decoded from state only.
REQ-018 IDLE: Index=0; Start=1 -> READ, SentCount cleared to 0; Start=0 -> stay.
REQ-019 READ: Address=Index presented for one cycle -> WAIT.
REQ-020 WAIT: RAMData is captured into TxData at the end of the cycle -> SEND.
REQ-021 SEND: TxValid=1, TxData held stable until handshake; on handshake SentCount+1, then Index==MessageLength-1 -> DONE, else Index+1 -> READ.
REQ-022 DONE: Done=1 for exactly one cycle -> IDLE; Index returns to 0.
REQ-023 Latency: Start sampled in cycle 0 -> TxValid first high in cycle 3; with TxReady held 1, one character every 3 cycles.
REQ-024 Start while Busy SHALL be ignored, with no effect on Index, SentCount or state.
REQ-025 TxReady high outside SEND SHALL have no effect; TxValid SHALL never be high outside SEND.
REQ-026 Index SHALL never exceed MessageLength-1; no wrap beyond message end.
REQ-027 SentCount SHALL hold its final value through IDLE until the next accepted Start.

Reset
REQ-028 On Reset=1 at an edge, in any state: state=IDLE, Index=0, Address=0, TxData=0, TxValid=0, Busy=0, Done=0, SentCount=0, ReadOrWrite=1.
REQ-029 Reset mid-message SHALL abandon the message; no handshake counts on the reset edge; Start is ignored on the reset edge.

Configuration
REQ-030 Macro NULL_STOP_EN: when defined, RAMData==0 captured in WAIT -> DONE directly with no TxValid for that character, SentCount unchanged; when undefined, all MessageLength characters are sent, including zero values.

Verification
REQ-031 Message "ECE433 Fall  2020",LF,CR,LF,0x00 loaded; TxReady=1; Start pulse at cycle 0 -> handshakes at cycles 3,6,...,63, data 'E','C','E','4',... in order, Done at cycle 64, SentCount=21 (undefined NULL_STOP_EN).
REQ-032 Same message, NULL_STOP_EN defined -> 20 handshakes, no TxValid for index 20, Done after index 20's WAIT, SentCount=20.
REQ-033 TxReady held 0 for 5 cycles during the first SEND -> TxValid=1 and TxData='E' stable all 5 cycles, exactly one handshake when TxReady rises.
REQ-034 Start re-pulsed at cycle 10 mid-message -> no effect; message completes as in REQ-031.
REQ-035 Reset asserted in SEND of index 7 -> next cycle IDLE, TxValid=0, SentCount=0, Address=0; new Start restarts from 'E'.
REQ-036 ReadOrWrite monitored continuously through all tests -> never 0.
